// File: rtl/memwb_stage.sv
// MEM->WB pipeline stage: load formatting, valid/ready handshake with a 2-entry skid buffer.
// Define MEMWB_FWD_EN to add the fwd_valid/fwd_rdn/fwd_rdd bypass outputs.
module memwb_stage #(
  parameter int unsigned WordSize = 32,
  parameter int unsigned RegAddrW = 5,
  parameter int unsigned OffW     = $clog2(WordSize / 8)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          wbs,
  input  logic [OffW-1:0]     byte_off,
  input  logic [RegAddrW-1:0] rdn_in,
  input  logic [WordSize-1:0] alu_out,
  input  logic [WordSize-1:0] mrd,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [RegAddrW-1:0] rdn,
  output logic [WordSize-1:0] rdd,
  output logic                we
`ifdef MEMWB_FWD_EN
  ,
  output logic                fwd_valid,
  output logic [RegAddrW-1:0] fwd_rdn,
  output logic [WordSize-1:0] fwd_rdd
`endif
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StFull  = 2'd1,
    StSkid  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [RegAddrW-1:0] rdn_q, rdn_d, skid_rdn_q, skid_rdn_d;
  logic [WordSize-1:0] rdd_q, rdd_d, skid_rdd_q, skid_rdd_d;
  logic [WordSize-1:0] fmt_data, lane_b, lane_h, lane_w;
  logic [OffW-1:0]     off_h, off_w;
  logic                accept, consume;

  // Lane extraction; alignment is forced by clearing low offset bits per access size.
  always_comb begin
    off_h      = byte_off;
    off_h[0]   = 1'b0;
    off_w      = byte_off;
    off_w[1:0] = 2'b00;
    lane_b     = mrd >> {byte_off, 3'b000};
    lane_h     = mrd >> {off_h, 3'b000};
    lane_w     = mrd >> {off_w, 3'b000};
    case (wbs)
      3'd0:    fmt_data = alu_out;
      3'd1:    fmt_data = WordSize'($signed(lane_b[7:0]));
      3'd2:    fmt_data = WordSize'($signed(lane_h[15:0]));
      3'd3:    fmt_data = WordSize'(lane_b[7:0]);
      3'd4:    fmt_data = WordSize'(lane_h[15:0]);
      3'd5:    fmt_data = mrd;
      // With a 32-bit word off_w is always 0, so these collapse to the full word.
      3'd6:    fmt_data = WordSize'($signed(lane_w[31:0]));
      3'd7:    fmt_data = WordSize'(lane_w[31:0]);
      default: fmt_data = mrd;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StEmpty) || (state_q == StFull);
    out_valid = (state_q == StFull) || (state_q == StSkid);
    rdn       = rdn_q;
    rdd       = rdd_q;
    we        = out_valid && (rdn_q != '0);
    accept    = in_valid && in_ready;
    consume   = out_valid && out_ready;
  end

  always_comb begin
    state_d    = state_q;
    rdn_d      = rdn_q;
    rdd_d      = rdd_q;
    skid_rdn_d = skid_rdn_q;
    skid_rdd_d = skid_rdd_q;
    case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d = StFull;
          rdn_d   = rdn_in;
          rdd_d   = fmt_data;
        end
      end
      StFull: begin
        if (accept && consume) begin
          rdn_d = rdn_in;
          rdd_d = fmt_data;
        end else if (accept) begin
          state_d    = StSkid;
          skid_rdn_d = rdn_in;
          skid_rdd_d = fmt_data;
        end else if (consume) begin
          state_d = StEmpty;
        end
      end
      StSkid: begin
        if (consume) begin
          state_d = StFull;
          rdn_d   = skid_rdn_q;
          rdd_d   = skid_rdd_q;
        end
      end
      default: state_d = StEmpty;
    endcase
    if (flush) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StEmpty;
      rdn_q      <= '0;
      rdd_q      <= '0;
      skid_rdn_q <= '0;
      skid_rdd_q <= '0;
    end else begin
      state_q    <= state_d;
      rdn_q      <= rdn_d;
      rdd_q      <= rdd_d;
      skid_rdn_q <= skid_rdn_d;
      skid_rdd_q <= skid_rdd_d;
    end
  end

`ifdef MEMWB_FWD_EN
  assign fwd_valid = we;
  assign fwd_rdn   = rdn_q;
  assign fwd_rdd   = rdd_q;
`endif

endmodule
